// File: rtl/neo_frame_loader.sv
// Pixel-write FIFO that feeds the NeoPixel strand controller one colour byte at a time.
// Frame commits become send_it pulses once every write accepted before the commit has been loaded.
module neo_frame_loader #(
    parameter int NUM_PIXELS = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] pix_data,
    input  logic [2:0]  pix_index,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        frame_commit,
    input  logic        ready_to_load,
    input  logic        ready_to_send,
    output logic [7:0]  color_level,
    output logic [1:0]  color_index,
    output logic [2:0]  pixel_index,
    output logic        load_color,
    output logic        send_it,
    output logic        busy,
    output logic        index_error,
    output logic [15:0] frames_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_G, LOAD_R, LOAD_B} state_t;

    state_t      r_state, w_next;
    logic [26:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        r_rtl_q;
    logic [2:0]  r_hold_idx;
    logic [23:0] r_hold_grb;
    logic        r_commit_pending;

    logic        w_empty, w_full, w_push, w_pop, w_load_ok, w_head_bad;
    logic [26:0] w_head;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign pix_ready  = ~w_full;
    assign w_push     = pix_valid & pix_ready;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_head_bad = {29'd0, w_head[26:24]} >= 32'(NUM_PIXELS);
    // The controller raises ready_to_load for a single cycle at end-of-packet and ignores
    // loads there; two consecutive high cycles are required before a load is trusted.
    assign w_load_ok  = ready_to_load & r_rtl_q;
    assign w_pop      = (r_state == IDLE) & ~w_empty & w_load_ok;
    assign busy       = ~w_empty | (r_state != IDLE) | r_commit_pending;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {pix_index, pix_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_rtl_q          <= 1'b0;
            r_hold_idx       <= '0;
            r_hold_grb       <= '0;
            r_commit_pending <= 1'b0;
            index_error      <= 1'b0;
            frames_sent      <= '0;
        end else begin
            r_state <= w_next;
            r_rtl_q <= ready_to_load;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr     <= r_rptr + 1'b1;
                r_hold_idx <= w_head[26:24];
                r_hold_grb <= w_head[23:0];
                if (w_head_bad) index_error <= 1'b1;
            end
            // A commit landing in the same cycle as a send starts the next frame's pending.
            if (frame_commit)  r_commit_pending <= 1'b1;
            else if (send_it)  r_commit_pending <= 1'b0;
            if (send_it) frames_sent <= frames_sent + 16'd1;
        end
    end

    always_comb begin
        w_next      = r_state;
        load_color  = 1'b0;
        send_it     = 1'b0;
        color_level = '0;
        color_index = '0;
        pixel_index = '0;
        case (r_state)
            IDLE: begin
                // Pop wins over send, so a send only happens once the FIFO has drained.
                if (w_pop) begin
                    if (!w_head_bad) w_next = LOAD_G;
                end else if (w_empty && r_commit_pending && ready_to_send) begin
                    send_it = 1'b1;
                end
            end
            LOAD_G: begin
                color_index = 2'b10;
                pixel_index = r_hold_idx;
                color_level = r_hold_grb[23:16];
                load_color  = w_load_ok;
                if (w_load_ok) w_next = LOAD_R;
            end
            LOAD_R: begin
                color_index = 2'b00;
                pixel_index = r_hold_idx;
                color_level = r_hold_grb[15:8];
                load_color  = w_load_ok;
                if (w_load_ok) w_next = LOAD_B;
            end
            LOAD_B: begin
                color_index = 2'b01;
                pixel_index = r_hold_idx;
                color_level = r_hold_grb[7:0];
                load_color  = w_load_ok;
                if (w_load_ok) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_neo_frame_loader.sv
// Scoreboard bench for neo_frame_loader: expected loads are queued per accepted write
// and checked against every load_color pulse seen by the monitor.
module tb_neo_frame_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pix_data = '0;
    logic [2:0]  pix_index = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        frame_commit = 1'b0;
    logic        ready_to_load = 1'b0;
    logic        ready_to_send = 1'b0;
    logic [7:0]  color_level;
    logic [1:0]  color_index;
    logic [2:0]  pixel_index;
    logic        load_color;
    logic        send_it;
    logic        busy;
    logic        index_error;
    logic [15:0] frames_sent;

    neo_frame_loader #(.NUM_PIXELS(5), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .pix_data(pix_data), .pix_index(pix_index), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_commit(frame_commit), .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .color_level(color_level), .color_index(color_index), .pixel_index(pixel_index),
        .load_color(load_color), .send_it(send_it), .busy(busy),
        .index_error(index_error), .frames_sent(frames_sent)
    );

    always #10 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          sends = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (load_color && send_it) chk("load_and_send", 32'(load_color & send_it), 0);
        if (load_color) begin
            if (exp_q.size() == 0) chk("unexpected_load", 32'(exp_q.size()), 1);
            else begin
                mon_e = exp_q.pop_front();
                chk("load", {19'd0, color_index, pixel_index, color_level}, {19'd0, mon_e});
            end
        end
        if (send_it) sends++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one write and returns one step after the accepting edge.
    task automatic push(input logic [2:0] idx, input logic [23:0] d);
        bit acc = 0;
        if (idx < 3'd5) begin
            exp_q.push_back({2'b10, idx, d[23:16]});
            exp_q.push_back({2'b00, idx, d[15:8]});
            exp_q.push_back({2'b01, idx, d[7:0]});
        end
        pix_valid = 1'b1;
        pix_index = idx;
        pix_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (pix_ready) begin acc = 1; break; end
        end
        if (!acc) chk("push_timeout", 32'(acc), 1);
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) begin done = 1; break; end
        end
        chk(tag, 32'(done), 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pat[5] = '{0, 1, 0, 1, 1};
        ready_to_load = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_pix_ready", 32'(pix_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load", 32'(load_color), 0);
        chk("rst_send", 32'(send_it), 0);
        chk("rst_frames", 32'(frames_sent), 0);
        chk("rst_idx_err", 32'(index_error), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        step(2);

        // single pixel, minimum latency
        push(3'd2, 24'h112233);
        @(negedge clock);
        chk("t1_pop_cycle", 32'(load_color), 0);
        @(negedge clock);
        chk("t1_first_load", 32'(load_color), 1);
        chk("t1_first_ci", 32'(color_index), 2);
        repeat (3) @(negedge clock);
        chk("t1_busy", 32'(busy), 0);
        @(posedge clock); #1;

        // commit held off by ready_to_send, two commits merge
        push(3'd1, 24'hA0B0C0);
        push(3'd3, 24'h0F1E2D);
        frame_commit = 1'b1; step(1); frame_commit = 1'b0;
        step(3);
        frame_commit = 1'b1; step(1); frame_commit = 1'b0;
        step(8);
        chk("t2_loads_done", 32'(exp_q.size()), 0);
        chk("t2_busy_pending", 32'(busy), 1);
        chk("t2_no_send_yet", 32'(sends), 0);
        ready_to_send = 1'b1;
        @(negedge clock);
        chk("t2_send_now", 32'(send_it), 1);
        @(posedge clock); #1;
        step(3);
        chk("t2_sends", 32'(sends), 1);
        chk("t2_frames", 32'(frames_sent), 1);
        chk("t2_busy", 32'(busy), 0);
        ready_to_send = 1'b0;

        // ready_to_load blip filtering while in LOAD_R
        push(3'd4, 24'hA1B2C3);
        @(negedge clock);
        @(negedge clock);
        chk("t3_g_load", 32'(load_color), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            ready_to_load = pat[i][0];
            @(negedge clock);
            chk("t3_r_load", 32'(load_color), 32'(i == 4));
            chk("t3_r_state", 32'(color_index), 0);
        end
        @(posedge clock); #1;
        ready_to_load = 1'b1;
        wait_idle("t3_drain");

        // fill FIFO with loads blocked, fifth write stalls
        ready_to_load = 1'b0;
        for (int i = 0; i < 4; i++) push(3'(i), 24'h100000 * (i + 1) + 24'h000203 * i);
        @(negedge clock);
        chk("t4_full", 32'(pix_ready), 0);
        @(posedge clock); #1;
        fork
            push(3'd4, 24'hDEADBE);
            begin
                repeat (3) begin
                    @(negedge clock);
                    chk("t4_stall", 32'(pix_ready), 0);
                end
                @(posedge clock); #1;
                ready_to_load = 1'b1;
            end
        join
        wait_idle("t4_drain");

        // out-of-range index dropped, sticky error
        chk("t5_err_before", 32'(index_error), 0);
        push(3'd5, 24'h555555);
        push(3'd0, 24'h010203);
        wait_idle("t5_drain");
        chk("t5_err_set", 32'(index_error), 1);
        step(5);
        chk("t5_err_sticky", 32'(index_error), 1);

        // reset mid-pixel with a full queue and a pending commit
        ready_to_load = 1'b0;
        for (int i = 0; i < 4; i++) push(3'(i), 24'h336699 + 24'(i));
        frame_commit = 1'b1; step(1); frame_commit = 1'b0;
        ready_to_load = 1'b1;
        repeat (3) @(negedge clock);
        @(negedge clock);
        chk("t6_in_load_r", {30'd0, load_color, color_index == 2'b00}, 3);
        #1;
        reset = 1'b1;
        exp_q.delete();
        ready_to_send = 1'b1;
        @(negedge clock);
        chk("t6_pix_ready", 32'(pix_ready), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_outs", {7'd0, load_color, send_it, color_level, color_index, pixel_index, 8'd0}, 0);
        chk("t6_idx_err", 32'(index_error), 0);
        chk("t6_frames", 32'(frames_sent), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("t6_no_send", 32'(sends), 1);
        chk("t6_busy_after", 32'(busy), 0);
        chk("t6_frames_after", 32'(frames_sent), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
